// File: rtl/uart_alu_host.sv
// Host-side initiator for the UART ALU link: sends A, B, OP through uart_tx
// and returns the single result byte from uart_rx, or flags a timeout.
module uart_alu_host #(
   parameter int N_DATA         = 8,
   parameter int NB_OPERATION   = 6,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int NB_TIMEOUT     = 22
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic [N_DATA-1:0]       i_cmd_a,
   input  logic [N_DATA-1:0]       i_cmd_b,
   input  logic [NB_OPERATION-1:0] i_cmd_op,
   output logic [N_DATA-1:0]       o_tx_data,
   output logic                    o_tx_start,
   input  logic                    i_tx_done,
   input  logic [N_DATA-1:0]       i_rx_data,
   input  logic                    i_rx_done,
   output logic                    o_rsp_valid,
   output logic [N_DATA-1:0]       o_rsp_data,
   output logic                    o_rsp_timeout
);

   typedef enum logic [2:0] {
      IDLE,
      SEND_A,
      WAIT_A,
      SEND_B,
      WAIT_B,
      SEND_OP,
      WAIT_OP,
      WAIT_RSP
   } state_t;

   localparam logic [NB_TIMEOUT-1:0] CNT_LAST =
      NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

   state_t state;
   state_t next_state;

   logic [N_DATA-1:0]       cmd_a;
   logic [N_DATA-1:0]       cmd_b;
   logic [NB_OPERATION-1:0] cmd_op;
   logic [N_DATA-1:0]       op_byte;
   logic [NB_TIMEOUT-1:0]   cnt;

   logic cmd_ready;
   logic rsp_valid;
   logic rsp_timeout;
   logic [N_DATA-1:0] rsp_data;

   logic accept;
   logic waiting;
   logic expired;
   logic ok_rsp;
   logic to_rsp;

   assign op_byte = N_DATA'(cmd_op);
   assign accept  = i_cmd_valid & cmd_ready;
   assign waiting = (state == WAIT_A) || (state == WAIT_B) ||
                    (state == WAIT_OP) || (state == WAIT_RSP);
   assign expired = waiting && (cnt == CNT_LAST);

   // A done pulse is checked before expiry so it wins a same-cycle tie.
   always_comb begin
      next_state = state;
      ok_rsp     = 1'b0;
      to_rsp     = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) next_state = SEND_A;
         end
         SEND_A: next_state = WAIT_A;
         WAIT_A: begin
            if (i_tx_done) begin
               next_state = SEND_B;
            end else if (expired) begin
               next_state = IDLE;
               to_rsp     = 1'b1;
            end
         end
         SEND_B: next_state = WAIT_B;
         WAIT_B: begin
            if (i_tx_done) begin
               next_state = SEND_OP;
            end else if (expired) begin
               next_state = IDLE;
               to_rsp     = 1'b1;
            end
         end
         SEND_OP: next_state = WAIT_OP;
         WAIT_OP: begin
            if (i_tx_done) begin
               next_state = WAIT_RSP;
            end else if (expired) begin
               next_state = IDLE;
               to_rsp     = 1'b1;
            end
         end
         WAIT_RSP: begin
            if (i_rx_done) begin
               next_state = IDLE;
               ok_rsp     = 1'b1;
            end else if (expired) begin
               next_state = IDLE;
               to_rsp     = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      o_tx_data  = '0;
      o_tx_start = 1'b0;
      unique case (state)
         SEND_A: begin
            o_tx_data  = cmd_a;
            o_tx_start = 1'b1;
         end
         WAIT_A: o_tx_data = cmd_a;
         SEND_B: begin
            o_tx_data  = cmd_b;
            o_tx_start = 1'b1;
         end
         WAIT_B: o_tx_data = cmd_b;
         SEND_OP: begin
            o_tx_data  = op_byte;
            o_tx_start = 1'b1;
         end
         WAIT_OP:  o_tx_data = op_byte;
         WAIT_RSP: o_tx_data = op_byte;
         default: o_tx_data = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= IDLE;
         cmd_ready   <= 1'b0;
         cmd_a       <= '0;
         cmd_b       <= '0;
         cmd_op      <= '0;
         cnt         <= '0;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_data    <= '0;
      end else begin
         state       <= next_state;
         cmd_ready   <= (next_state == IDLE);
         rsp_valid   <= ok_rsp | to_rsp;
         rsp_timeout <= to_rsp;
         if (accept) begin
            cmd_a  <= i_cmd_a;
            cmd_b  <= i_cmd_b;
            cmd_op <= i_cmd_op;
         end
         // Every state change clears the counter, so each WAIT starts at 0.
         if (next_state != state) begin
            cnt <= '0;
         end else if (waiting) begin
            cnt <= cnt + 1'b1;
         end
         if (ok_rsp) rsp_data <= i_rx_data;
      end
   end

   assign o_cmd_ready   = cmd_ready;
   assign o_rsp_valid   = rsp_valid;
   assign o_rsp_data    = rsp_data;
   assign o_rsp_timeout = rsp_timeout;

endmodule

// File: tb/tb_uart_alu_host.sv
// Directed bench for uart_alu_host; the bench plays the uart_tx/uart_rx
// and far-end ALU, producing done pulses and result bytes itself.
module tb_uart_alu_host;

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic [5:0] cmd_op;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_done;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   uart_alu_host #(
      .N_DATA(8),
      .NB_OPERATION(6),
      .TIMEOUT_CYCLES(50),
      .NB_TIMEOUT(6)
   ) dut (
      .i_clk(clk),
      .i_rst(rst_n),
      .i_cmd_valid(cmd_valid),
      .o_cmd_ready(cmd_ready),
      .i_cmd_a(cmd_a),
      .i_cmd_b(cmd_b),
      .i_cmd_op(cmd_op),
      .o_tx_data(tx_data),
      .o_tx_start(tx_start),
      .i_tx_done(tx_done),
      .i_rx_data(rx_data),
      .i_rx_done(rx_done),
      .o_rsp_valid(rsp_valid),
      .o_rsp_data(rsp_data),
      .o_rsp_timeout(rsp_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] alu(input logic [5:0] op,
                                      input logic [7:0] a,
                                      input logic [7:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         default: return 8'h00;
      endcase
   endfunction

   // Far-end engine. Cycle 0 is the accept cycle; n counts negedges after it.
   // kt: cycles from each start pulse to its tx_done.
   // kr: cycles from the third tx_done to rx_done.
   task automatic run_cmd(
      input  logic [7:0]  a,
      input  logic [7:0]  b,
      input  logic [5:0]  op,
      input  int          kt,
      input  int          kr,
      input  bit          rx_en,
      input  logic [7:0]  rx_byte,
      input  bit          glitch,
      input  bit          keep_valid,
      output logic [23:0] bytes,
      output int          nstart,
      output int          t_first,
      output bit          got,
      output logic        to,
      output logic [7:0]  data,
      output int          lat,
      output int          wait_rdy,
      output int          bad
   );
      int n;
      int ndone;
      int t_tx;
      int t_rx;
      logic [7:0] last;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_valid = 1'b1;
      bytes     = '0;
      nstart    = 0;
      t_first   = -1;
      got       = 1'b0;
      to        = 1'bx;
      data      = 8'hxx;
      lat       = -1;
      bad       = 0;
      wait_rdy  = 0;
      ndone     = 0;
      t_tx      = -1;
      t_rx      = -1;
      last      = 8'h00;
      while (!cmd_ready && wait_rdy < 200) begin
         @(negedge clk);
         wait_rdy++;
      end
      if (!cmd_ready) begin
         cmd_valid = 1'b0;
         return;
      end
      n = 0;
      while (!got && n < 400) begin
         @(negedge clk);
         n++;
         tx_done = 1'b0;
         rx_done = 1'b0;
         if (n == 1 && !keep_valid) begin
            cmd_valid = 1'b0;
            cmd_a     = ~a;
            cmd_b     = ~b;
            cmd_op    = ~op;
         end
         if (rsp_valid) begin
            got  = 1'b1;
            to   = rsp_timeout;
            data = rsp_data;
            lat  = n;
         end else begin
            if (rsp_timeout) bad++;
            if (cmd_ready) bad++;
            if (nstart > 0 && !tx_start && tx_data !== last) bad++;
         end
         if (tx_start) begin
            if (got) bad++;
            if (nstart < 3) bytes[8*nstart +: 8] = tx_data;
            if (t_first < 0) t_first = n;
            last = tx_data;
            nstart++;
            t_tx = n + kt;
            if (glitch) tx_done = 1'b1;
         end
         if (!got && n == t_tx) begin
            tx_done = 1'b1;
            ndone++;
            if (ndone == 3 && rx_en) t_rx = n + kr;
         end
         if (!got && n == t_rx) begin
            rx_done = 1'b1;
            rx_data = rx_byte;
         end
      end
      tx_done = 1'b0;
      rx_done = 1'b0;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      cmd_valid = 1'b1;
      cmd_a     = 8'h12;
      cmd_b     = 8'h34;
      cmd_op    = OP_ADD;
      tx_done   = 1'b0;
      rx_done   = 1'b0;
      rx_data   = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 0", cmd_ready);
      end
      n_checks++;
      if (tx_start !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tx_start: got %b expected 0", tx_start);
      end
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rsp: got v=%b t=%b expected 0 0",
                  rsp_valid, rsp_timeout);
      end
      n_checks++;
      if (rsp_data !== 8'h00 || tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_data: got rsp=%h tx=%h expected 00 00",
                  rsp_data, tx_data);
      end
      cmd_valid = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_loopback;
      logic [23:0] bytes;
      int nstart, t_first, lat, wr, bad;
      bit got;
      logic to;
      logic [7:0] data;
      run_cmd(8'h05, 8'h03, OP_ADD, 3, 5, 1'b1,
              alu(OP_ADD, 8'h05, 8'h03), 1'b0, 1'b0,
              bytes, nstart, t_first, got, to, data, lat, wr, bad);
      n_checks++;
      if (bytes !== {2'b00, OP_ADD, 8'h03, 8'h05} || nstart != 3) begin
         n_fail++;
         $display("FAIL loop_bytes: got %h (%0d starts) expected %h (3)",
                  bytes, nstart, {2'b00, OP_ADD, 8'h03, 8'h05});
      end
      n_checks++;
      if (t_first != 1) begin
         n_fail++;
         $display("FAIL loop_first_start: got cycle %0d expected 1", t_first);
      end
      n_checks++;
      if (!got || data !== 8'h08 || to !== 1'b0) begin
         n_fail++;
         $display("FAIL loop_rsp: got v=%b d=%h t=%b expected 1 08 0",
                  got, data, to);
      end
      n_checks++;
      if (lat != 4 + 3 * 3 + 5) begin
         n_fail++;
         $display("FAIL loop_latency: got %0d expected %0d", lat, 18);
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL loop_protocol: got %0d violations expected 0", bad);
      end
   endtask

   task automatic test_back_to_back;
      logic [23:0] bytes;
      int nstart, t_first, lat, wr, bad;
      bit got;
      logic to;
      logic [7:0] data;
      @(negedge clk);
      run_cmd(8'hF0, 8'h0F, OP_OR, 2, 4, 1'b1,
              alu(OP_OR, 8'hF0, 8'h0F), 1'b0, 1'b1,
              bytes, nstart, t_first, got, to, data, lat, wr, bad);
      n_checks++;
      if (!got || data !== 8'hFF || to !== 1'b0 || bad != 0) begin
         n_fail++;
         $display("FAIL b2b_first: got v=%b d=%h t=%b bad=%0d expected 1 FF 0 0",
                  got, data, to, bad);
      end
      n_checks++;
      if (lat != 4 + 3 * 2 + 4) begin
         n_fail++;
         $display("FAIL b2b_first_latency: got %0d expected %0d", lat, 14);
      end
      run_cmd(8'h10, 8'h20, OP_SUB, 2, 1, 1'b1,
              alu(OP_SUB, 8'h10, 8'h20), 1'b1, 1'b0,
              bytes, nstart, t_first, got, to, data, lat, wr, bad);
      n_checks++;
      if (wr != 0) begin
         n_fail++;
         $display("FAIL b2b_accept: got %0d wait cycles expected 0", wr);
      end
      n_checks++;
      if (!got || data !== 8'hF0 || to !== 1'b0 || bad != 0) begin
         n_fail++;
         $display("FAIL b2b_second: got v=%b d=%h t=%b bad=%0d expected 1 F0 0 0",
                  got, data, to, bad);
      end
      n_checks++;
      if (lat != 4 + 3 * 2 + 1 || bytes !== {2'b00, OP_SUB, 8'h20, 8'h10}) begin
         n_fail++;
         $display("FAIL b2b_second_seq: got lat=%0d bytes=%h expected 11 %h",
                  lat, bytes, {2'b00, OP_SUB, 8'h20, 8'h10});
      end
   endtask

   task automatic test_timeout;
      logic [23:0] bytes;
      int nstart, t_first, lat, wr, bad;
      bit got;
      logic to;
      logic [7:0] data;
      int seen;
      @(negedge clk);
      run_cmd(8'h11, 8'h22, OP_ADD, 1, 0, 1'b0, 8'h00, 1'b0, 1'b0,
              bytes, nstart, t_first, got, to, data, lat, wr, bad);
      n_checks++;
      if (!got || to !== 1'b1 || data !== 8'hF0) begin
         n_fail++;
         $display("FAIL rsp_timeout: got v=%b t=%b d=%h expected 1 1 F0",
                  got, to, data);
      end
      n_checks++;
      if (lat != 7 + 50 || bad != 0) begin
         n_fail++;
         $display("FAIL rsp_timeout_cycle: got %0d bad=%0d expected 57 0",
                  lat, bad);
      end
      @(negedge clk);
      run_cmd(8'h33, 8'h44, OP_ADD, 1, 50, 1'b1, 8'h3C, 1'b0, 1'b0,
              bytes, nstart, t_first, got, to, data, lat, wr, bad);
      n_checks++;
      if (!got || to !== 1'b0 || data !== 8'h3C || lat != 57) begin
         n_fail++;
         $display("FAIL tie_done_wins: got v=%b t=%b d=%h lat=%0d expected 1 0 3C 57",
                  got, to, data, lat);
      end
      @(negedge clk);
      run_cmd(8'h01, 8'h02, OP_ADD, 60, 1, 1'b1, 8'h55, 1'b0, 1'b0,
              bytes, nstart, t_first, got, to, data, lat, wr, bad);
      n_checks++;
      if (!got || to !== 1'b1 || data !== 8'h3C ||
          lat != 52 || nstart != 1) begin
         n_fail++;
         $display("FAIL tx_timeout: got v=%b t=%b d=%h lat=%0d starts=%0d expected 1 1 3C 52 1",
                  got, to, data, lat, nstart);
      end
      seen = 0;
      rx_data = 8'h99;
      rx_done = 1'b1;
      tx_done = 1'b1;
      repeat (10) begin
         @(negedge clk);
         rx_done = 1'b0;
         tx_done = 1'b0;
         if (rsp_valid || tx_start) seen++;
      end
      n_checks++;
      if (seen != 0 || rsp_data !== 8'h3C) begin
         n_fail++;
         $display("FAIL stray_idle: got %0d events d=%h expected 0 3C",
                  seen, rsp_data);
      end
   endtask

   task automatic test_reset_mid;
      logic [23:0] bytes;
      int nstart, t_first, lat, wr, bad;
      bit got;
      logic to;
      logic [7:0] data;
      int seen;
      int w;
      @(negedge clk);
      cmd_a     = 8'h5A;
      cmd_b     = 8'hA5;
      cmd_op    = OP_ADD;
      cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      n_checks++;
      if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL mid_send_b: got start=%b d=%h expected 1 A5",
                  tx_start, tx_data);
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (tx_start !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 ||
          tx_data !== 8'h00 || rsp_data !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got s=%b r=%b v=%b tx=%h d=%h expected 0 0 0 00 00",
                  tx_start, cmd_ready, rsp_valid, tx_data, rsp_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      rx_data = 8'h77;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         tx_done = i[0];
         rx_done = ~i[0];
         if (rsp_valid || tx_start) seen++;
      end
      tx_done = 1'b0;
      rx_done = 1'b0;
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL mid_no_rsp: got %0d events expected 0", seen);
      end
      @(negedge clk);
      run_cmd(8'hAA, 8'h0F, OP_AND, 2, 3, 1'b1,
              alu(OP_AND, 8'hAA, 8'h0F), 1'b0, 1'b0,
              bytes, nstart, t_first, got, to, data, lat, wr, bad);
      n_checks++;
      if (!got || to !== 1'b0 || data !== 8'h0A || lat != 13 || bad != 0) begin
         n_fail++;
         $display("FAIL after_reset_cmd: got v=%b t=%b d=%h lat=%0d bad=%0d expected 1 0 0A 13 0",
                  got, to, data, lat, bad);
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
